riscv_vec_vlen_sequencer: RTL and testbench

Consumer side of the vector-length handshake. It accepts an application vector length, already clamped to the hardware vector length by the vcfg/setvl datapath, together with the active bank count, and breaks it into per-cycle issue beats. Each beat covers up to one element per bank and is sent to the vector lane issue stage under a valid/ready handshake. It pulses `done` when every element has been issued.

---
 rtl/riscv_vec_pkg.sv | 21 ++
 rtl/riscv_vec_vlen_sequencer.sv | 94 +++++++++
 tb/tb_riscv_vec_vlen_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/riscv_vec_pkg.sv
// Shared vector-sequencer types, default widths and the issue bank-mask helper.
package riscv_vec_pkg;

  localparam int VLEN_W = 12;
  localparam int NBANK  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Low cnt bits set; cnt above NBANK saturates to all ones.
  function automatic logic [NBANK-1:0] bank_mask(input logic [3:0] cnt);
    logic [NBANK-1:0] m;
    m = '0;
    for (int i = 0; i < NBANK; i++) m[i] = (i < int'(cnt));
    return m;
  endfunction

endpackage

// File: rtl/riscv_vec_vlen_sequencer.sv
// Splits a clamped vector length into per-cycle beats of up to one element per bank.
// First beat one cycle after accept; beats hold stable while iss_ready is low; done follows the last beat.
module riscv_vec_vlen_sequencer
  import riscv_vec_pkg::*;
#(
  parameter int VLEN_W = riscv_vec_pkg::VLEN_W,
  parameter int NBANK  = riscv_vec_pkg::NBANK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [VLEN_W-1:0] cmd_vlen,
  input  logic [3:0]        vec_bank_count,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [VLEN_W-1:0] iss_start,
  output logic [3:0]        iss_cnt,
  output logic [NBANK-1:0]  iss_bank_mask,
  output logic              iss_last,
  output logic              done,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [VLEN_W-1:0] rem_q;
  logic [VLEN_W-1:0] start_q;
  logic [3:0]        banks_q;
  logic [3:0]        banks_in;
  logic [3:0]        cnt_c;
  logic              last_c;
  logic              cmd_acc;
  logic              beat;

  // Illegal bank counts are folded into 1..NBANK at accept time.
  always_comb begin
    banks_in = vec_bank_count;
    if (vec_bank_count == 4'd0)
      banks_in = 4'd1;
    else if (vec_bank_count > 4'(NBANK))
      banks_in = 4'(NBANK);
  end

  always_comb begin
    cnt_c  = banks_q;
    last_c = 1'b0;
    if (rem_q <= VLEN_W'(banks_q)) begin
      cnt_c  = rem_q[3:0];
      last_c = 1'b1;
    end
  end

  assign cmd_acc = cmd_valid & (state_q == IDLE);
  assign beat    = iss_ready & (state_q == ISSUE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_acc) state_d = (cmd_vlen == '0) ? FIN : ISSUE;
      ISSUE:   if (beat && last_c) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      start_q <= '0;
      banks_q <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_acc) begin
        rem_q   <= cmd_vlen;
        start_q <= '0;
        banks_q <= banks_in;
      end else if (beat) begin
        rem_q   <= rem_q - VLEN_W'(cnt_c);
        start_q <= start_q + VLEN_W'(cnt_c);
      end
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign iss_valid     = (state_q == ISSUE);
  assign done          = (state_q == FIN);
  assign busy          = (state_q != IDLE);
  assign iss_start     = start_q;
  assign iss_cnt       = iss_valid ? cnt_c : 4'd0;
  assign iss_last      = iss_valid & last_c;
  assign iss_bank_mask = iss_valid ? NBANK'(bank_mask(cnt_c)) : '0;

endmodule

// File: tb/tb_riscv_vec_vlen_sequencer.sv
// Randomized bench for riscv_vec_vlen_sequencer against a list-of-beats reference model.
module tb_riscv_vec_vlen_sequencer;

  localparam int VLEN_W = 12;
  localparam int NBANK  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [VLEN_W-1:0] cmd_vlen = '0;
  logic [3:0]        vec_bank_count = 4'd0;
  logic              iss_valid;
  logic              iss_ready = 1'b0;
  logic [VLEN_W-1:0] iss_start;
  logic [3:0]        iss_cnt;
  logic [NBANK-1:0]  iss_bank_mask;
  logic              iss_last;
  logic              done;
  logic              busy;

  int total = 0;
  int bad   = 0;

  int e_start[$];
  int e_cnt[$];
  int e_last[$];

  riscv_vec_vlen_sequencer #(.VLEN_W(VLEN_W), .NBANK(NBANK)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vlen(cmd_vlen),
    .vec_bank_count(vec_bank_count),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_start(iss_start),
    .iss_cnt(iss_cnt), .iss_bank_mask(iss_bank_mask), .iss_last(iss_last),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected beat list: walk the vector in strides of the effective bank count.
  task automatic build_model(input int v, input int b);
    int eb;
    int s;
    int c;
    e_start.delete(); e_cnt.delete(); e_last.delete();
    eb = (b == 0) ? 1 : (b > NBANK ? NBANK : b);
    s = 0;
    while (s < v) begin
      c = (v - s < eb) ? v - s : eb;
      e_start.push_back(s);
      e_cnt.push_back(c);
      e_last.push_back((s + c == v) ? 1 : 0);
      s += c;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    chk({tag, "_iss_valid"}, int'(iss_valid), 0);
    chk({tag, "_iss_cnt"}, int'(iss_cnt), 0);
    chk({tag, "_iss_mask"}, int'(iss_bank_mask), 0);
    chk({tag, "_iss_last"}, int'(iss_last), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // Issues one command, then checks every cycle until it completes.
  task automatic run_cmd(input int v, input int b, input int rdy_pct);
    int idx;
    int cyc;
    int budget;
    build_model(v, b);
    budget = 3 * e_cnt.size() + 200;
    @(negedge clk);
    chk("pre_cmd_ready", int'(cmd_ready), 1);
    chk("pre_busy", int'(busy), 0);
    cmd_valid = 1'b1;
    cmd_vlen = VLEN_W'(v);
    vec_bank_count = 4'(b);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_vlen = VLEN_W'($urandom);
    vec_bank_count = 4'($urandom);
    idx = 0;
    cyc = 0;
    while (idx < e_cnt.size() && cyc < budget) begin
      @(negedge clk);
      chk("beat_valid", int'(iss_valid), 1);
      chk("beat_start", int'(iss_start), e_start[idx]);
      chk("beat_cnt", int'(iss_cnt), e_cnt[idx]);
      chk("beat_mask", int'(iss_bank_mask), (1 << e_cnt[idx]) - 1);
      chk("beat_last", int'(iss_last), e_last[idx]);
      chk("beat_done", int'(done), 0);
      chk("beat_cmd_ready", int'(cmd_ready), 0);
      iss_ready = ($urandom_range(99) < rdy_pct);
      vec_bank_count = 4'($urandom);
      @(posedge clk);
      if (iss_ready) idx++;
      #1;
      iss_ready = 1'b0;
      cyc++;
    end
    if (idx < e_cnt.size()) chk("beat_timeout", idx, e_cnt.size());
    @(negedge clk);
    chk("fin_done", int'(done), 1);
    chk("fin_iss_valid", int'(iss_valid), 0);
    chk("fin_cmd_ready", int'(cmd_ready), 0);
    chk("fin_busy", int'(busy), 1);
    @(negedge clk);
    chk("post_done", int'(done), 0);
    chk("post_cmd_ready", int'(cmd_ready), 1);
  endtask

  initial begin
    #1;
    chk_idle_outputs("reset");
    chk("reset_start", int'(iss_start), 0);
    @(negedge clk);
    reset = 1'b1;

    run_cmd(20, 8, 100);
    run_cmd(0, 5, 100);
    run_cmd(10, 3, 50);
    run_cmd(2, 0, 100);
    run_cmd(9, 12, 70);
    run_cmd(4095, 1, 100);
    run_cmd(4095, 8, 80);

    // Abort mid-command: reset during the second beat of a 20-element vector.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_vlen = VLEN_W'(20);
    vec_bank_count = 4'd8;
    iss_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_beat1_start", int'(iss_start), 0);
    @(negedge clk);
    chk("abort_beat2_start", int'(iss_start), 8);
    iss_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk_idle_outputs("abort");
    chk("abort_start", int'(iss_start), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_hold_done", int'(done), 0);
      chk("abort_hold_busy", int'(busy), 0);
    end
    reset = 1'b1;
    run_cmd(5, 4, 100);

    for (int n = 0; n < 25; n++)
      run_cmd($urandom_range(40), $urandom_range(15), 30 + $urandom_range(70));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
